cpu7_csr_excp: RTL
==================

// Module: cpu7_csr_excp
// PURPOSE
//  Next-generation CSR file for the cpu7 core. Adds ECFG/ESTAT with interrupt pending/enable,
//  exception-code capture, ERTN return, and a programmable timer (TID/TCFG/TVAL/TICLR).
//  Sits beside the execute stage: read/write via csrrd/csrwr/csrxchg, exception/ertn from ecl.
// PARAMETERS
//  GRLEN        32     datapath / CSR width
//  CSR_BIT      14     CSR address width
//  NUM_HWI      8      external hardware interrupt lines, 1..8, mapped to ESTAT.IS[2+:NUM_HWI]
//  TIMER_W      32     timer counter width, <= GRLEN, >= 3
//  RESET_EENTRY 0      EENTRY value after reset
// PORTS
//  clk          in   1          core clock
//  resetn       in   1          asynchronous active-low reset
//  csr_raddr    in   CSR_BIT    read address
//  csr_rdata    out  GRLEN      read data, combinational from csr_raddr
//  csr_waddr    in   CSR_BIT    write address
//  csr_wdata    in   GRLEN      write data (already merged with mask for csrxchg)
//  csr_wen      in   1          write strobe
//  excp_e       in   1          exception commit in E stage
//  excp_ecode   in   6          exception code for ESTAT.Ecode
//  excp_pc      in   GRLEN      PC of faulting instruction
//  ertn_e       in   1          ERTN commit in E stage
//  hwi          in   NUM_HWI    level hardware interrupts
//  csr_eentry   out  GRLEN      exception entry address
//  csr_era      out  GRLEN      exception return address
//  csr_plv      out  2          current CRMD.PLV
//  csr_int_req  out  1          interrupt request to ecl
// BEHAVIOUR
//  Map: CRMD 0x0 {IE[2],PLV[1:0]}; PRMD 0x1 {PIE[2],PPLV[1:0]}; ECFG 0x4 LIE[12:0], LIE[10] RO 0;
//   ESTAT 0x5 {Ecode[21:16],IS[12:0]}; ERA 0x6; EENTRY 0xc, [5:0] RO 0; TID 0x40;
//   TCFG 0x41 {InitVal[TIMER_W-1:2],Periodic[1],En[0]}; TVAL 0x42 RO; TICLR 0x44 W1C bit0, reads 0.
//  Unmapped and unimplemented bits read 0; writes to unmapped addresses ignored.
//  Reset: every register 0 except EENTRY=RESET_EENTRY; csr_int_req=0, csr_plv=0.
//  Writes take effect at next clk edge; same-cycle read of a written CSR returns old value.
//  Priority per cycle: excp_e > ertn_e > csr_wen on CRMD/PRMD/ERA/ESTAT.Ecode; excp_e and ertn_e
//   together: excp_e wins, ertn ignored. Non-conflicting CSR writes still take effect.
//  Exception: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0,
//   ERA<=excp_pc, ESTAT.Ecode<=excp_ecode.
//  ERTN: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; PRMD unchanged.
//  ESTAT write: only IS[1:0] (software interrupts) writable; all other bits ignored.
//  IS[2+:NUM_HWI] <= hwi every cycle (registered, 1-cycle latency); unused IS[9:2+NUM_HWI] = 0.
//  Timer: TCFG write loads TVAL<={InitVal,2'b00} (zero-extended to TIMER_W). Each cycle with
//   En=1 and TVAL!=0: TVAL<=TVAL-1. On the edge where TVAL goes 1->0: IS[11]<=1; if Periodic,
//   TVAL<={InitVal,2'b00} instead of 0. TVAL==0 with En=1: holds, no further IS[11] sets.
//   En=0: TVAL frozen. TCFG write and expiry same cycle: TCFG write wins (reload, no IS[11] set).
//  TICLR bit0 write clears IS[11]; simultaneous expiry set wins (IS[11] stays 1).
//  csr_int_req = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
//  Reset mid-operation: all state returns to reset values immediately, timer stops.
//  TID: plain R/W GRLEN register, no side effects.
// TESTING
//  Write CRMD=0x7, then excp_e with ecode=0x09, pc=0x1c000040 -> CRMD=0x0, PRMD=0x7,
//   ERA=0x1c000040, ESTAT[21:16]=0x09; next ertn_e -> CRMD=0x7, csr_plv=3.
//  excp_e, ertn_e and csr_wen to CRMD=0x4 same cycle -> exception result only, CRMD=0x0.
//  TCFG=0x11 (InitVal=4, one-shot): TVAL 16,15..1,0; IS[11]=1 exactly 16 cycles after write,
//   TVAL holds 0; TICLR=1 -> IS[11]=0 next cycle.
//  TCFG=0x0b (InitVal=2, periodic): IS[11] set every 8 cycles, TVAL reloads 8; TICLR write on
//   expiry cycle -> IS[11] remains 1.
//  ECFG=0x4, CRMD.IE=1, hwi[0] 0->1 -> IS[2]=1 and csr_int_req=1 one cycle later; IE=0 -> req 0.
//  Write ESTAT=0xFFFFFFFF -> only IS[1:0]=3 read back; EENTRY=0xFFFFFFFF -> reads 0xFFFFFFC0.

Source files
------------

// File: rtl/cpu7_csr_excp_if.sv
// CSR access, exception/ertn commit and interrupt bundle between the execute stage and cpu7_csr_excp.
// master = execute/ecl side, slave = CSR file.
interface cpu7_csr_excp_if #(
   parameter int GRLEN   = 32,
   parameter int CSR_BIT = 14,
   parameter int NUM_HWI = 8
);
   logic [CSR_BIT-1:0] csr_raddr;
   logic [GRLEN-1:0]   csr_rdata;
   logic [CSR_BIT-1:0] csr_waddr;
   logic [GRLEN-1:0]   csr_wdata;
   logic               csr_wen;
   logic               excp_e;
   logic [5:0]         excp_ecode;
   logic [GRLEN-1:0]   excp_pc;
   logic               ertn_e;
   logic [NUM_HWI-1:0] hwi;
   logic [GRLEN-1:0]   csr_eentry;
   logic [GRLEN-1:0]   csr_era;
   logic [1:0]         csr_plv;
   logic               csr_int_req;

   modport master (
      output csr_raddr, csr_waddr, csr_wdata, csr_wen,
             excp_e, excp_ecode, excp_pc, ertn_e, hwi,
      input  csr_rdata, csr_eentry, csr_era, csr_plv, csr_int_req
   );

   modport slave (
      input  csr_raddr, csr_waddr, csr_wdata, csr_wen,
             excp_e, excp_ecode, excp_pc, ertn_e, hwi,
      output csr_rdata, csr_eentry, csr_era, csr_plv, csr_int_req
   );
endinterface

// File: rtl/cpu7_csr_excp.sv
// cpu7 CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY, exception entry and ERTN return,
// and the TID/TCFG/TVAL/TICLR timer raising ESTAT.IS[11].
module cpu7_csr_excp #(
   parameter int               GRLEN        = 32,
   parameter int               CSR_BIT      = 14,
   parameter int               NUM_HWI      = 8,
   parameter int               TIMER_W      = 32,
   parameter logic [GRLEN-1:0] RESET_EENTRY = '0
) (
   input logic              clk,
   input logic              resetn,
   cpu7_csr_excp_if.slave   bus
);
   localparam logic [CSR_BIT-1:0] A_CRMD   = 14'h000;
   localparam logic [CSR_BIT-1:0] A_PRMD   = 14'h001;
   localparam logic [CSR_BIT-1:0] A_ECFG   = 14'h004;
   localparam logic [CSR_BIT-1:0] A_ESTAT  = 14'h005;
   localparam logic [CSR_BIT-1:0] A_ERA    = 14'h006;
   localparam logic [CSR_BIT-1:0] A_EENTRY = 14'h00c;
   localparam logic [CSR_BIT-1:0] A_TID    = 14'h040;
   localparam logic [CSR_BIT-1:0] A_TCFG   = 14'h041;
   localparam logic [CSR_BIT-1:0] A_TVAL   = 14'h042;
   localparam logic [CSR_BIT-1:0] A_TICLR  = 14'h044;
   localparam logic [TIMER_W-1:0] TV_ONE   = {{(TIMER_W-1){1'b0}}, 1'b1};

   logic [2:0]         crmd_q,  crmd_d;
   logic [2:0]         prmd_q,  prmd_d;
   logic [12:0]        lie_q,   lie_d;
   logic [1:0]         swi_q,   swi_d;
   logic [NUM_HWI-1:0] hwi_q;
   logic               ti_q,    ti_d;
   logic [5:0]         ecode_q, ecode_d;
   logic [GRLEN-1:0]   era_q,   era_d;
   logic [GRLEN-7:0]   eentry_q, eentry_d;
   logic [GRLEN-1:0]   tid_q,   tid_d;
   logic [TIMER_W-1:0] tcfg_q,  tcfg_d;
   logic [TIMER_W-1:0] tval_q,  tval_d;
   logic [12:0]        is_s;
   logic [TIMER_W-1:0] init_s;
   logic               expire_s;

   logic wr_crmd_s, wr_prmd_s, wr_ecfg_s, wr_estat_s, wr_era_s;
   logic wr_eentry_s, wr_tid_s, wr_tcfg_s, wr_ticlr_s;

   assign wr_crmd_s   = bus.csr_wen && (bus.csr_waddr == A_CRMD);
   assign wr_prmd_s   = bus.csr_wen && (bus.csr_waddr == A_PRMD);
   assign wr_ecfg_s   = bus.csr_wen && (bus.csr_waddr == A_ECFG);
   assign wr_estat_s  = bus.csr_wen && (bus.csr_waddr == A_ESTAT);
   assign wr_era_s    = bus.csr_wen && (bus.csr_waddr == A_ERA);
   assign wr_eentry_s = bus.csr_wen && (bus.csr_waddr == A_EENTRY);
   assign wr_tid_s    = bus.csr_wen && (bus.csr_waddr == A_TID);
   assign wr_tcfg_s   = bus.csr_wen && (bus.csr_waddr == A_TCFG);
   assign wr_ticlr_s  = bus.csr_wen && (bus.csr_waddr == A_TICLR);

   assign init_s = {tcfg_q[TIMER_W-1:2], 2'b00};

   // Assemble ESTAT.IS: software bits, sampled hardware lines, timer; IS[10]/IS[12] unimplemented.
   always_comb begin
      is_s               = '0;
      is_s[1:0]          = swi_q;
      is_s[2 +: NUM_HWI] = hwi_q;
      is_s[11]           = ti_q;
   end

   // Next-state logic; exception beats ertn, and both beat software writes to the same fields.
   always_comb begin
      crmd_d   = crmd_q;
      prmd_d   = prmd_q;
      era_d    = era_q;
      ecode_d  = ecode_q;
      lie_d    = lie_q;
      swi_d    = swi_q;
      eentry_d = eentry_q;
      tid_d    = tid_q;
      tcfg_d   = tcfg_q;
      tval_d   = tval_q;
      expire_s = 1'b0;

      if (bus.excp_e) begin
         crmd_d  = 3'b000;
         prmd_d  = crmd_q;
         era_d   = bus.excp_pc;
         ecode_d = bus.excp_ecode;
      end else if (bus.ertn_e) begin
         crmd_d  = prmd_q;
      end else begin
         if (wr_crmd_s) crmd_d = bus.csr_wdata[2:0]; else crmd_d = crmd_q;
         if (wr_prmd_s) prmd_d = bus.csr_wdata[2:0]; else prmd_d = prmd_q;
         if (wr_era_s)  era_d  = bus.csr_wdata;      else era_d  = era_q;
      end

      if (wr_ecfg_s)   lie_d    = bus.csr_wdata[12:0] & 13'h1bff; else lie_d    = lie_q;
      if (wr_estat_s)  swi_d    = bus.csr_wdata[1:0];             else swi_d    = swi_q;
      if (wr_eentry_s) eentry_d = bus.csr_wdata[GRLEN-1:6];       else eentry_d = eentry_q;
      if (wr_tid_s)    tid_d    = bus.csr_wdata;                  else tid_d    = tid_q;

      // A TCFG write reloads and masks a same-cycle expiry.
      if (wr_tcfg_s) begin
         tcfg_d = bus.csr_wdata[TIMER_W-1:0];
         tval_d = {bus.csr_wdata[TIMER_W-1:2], 2'b00};
      end else if (tcfg_q[0] && (tval_q != '0)) begin
         if (tval_q == TV_ONE) begin
            expire_s = 1'b1;
            tval_d   = tcfg_q[1] ? init_s : '0;
         end else begin
            tval_d   = tval_q - TV_ONE;
         end
      end else begin
         tval_d = tval_q;
      end

      if (expire_s)                          ti_d = 1'b1;
      else if (wr_ticlr_s && bus.csr_wdata[0]) ti_d = 1'b0;
      else                                   ti_d = ti_q;
   end

   // State registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         crmd_q   <= '0;
         prmd_q   <= '0;
         lie_q    <= '0;
         swi_q    <= '0;
         hwi_q    <= '0;
         ti_q     <= 1'b0;
         ecode_q  <= '0;
         era_q    <= '0;
         eentry_q <= RESET_EENTRY[GRLEN-1:6];
         tid_q    <= '0;
         tcfg_q   <= '0;
         tval_q   <= '0;
      end else begin
         crmd_q   <= crmd_d;
         prmd_q   <= prmd_d;
         lie_q    <= lie_d;
         swi_q    <= swi_d;
         hwi_q    <= bus.hwi;
         ti_q     <= ti_d;
         ecode_q  <= ecode_d;
         era_q    <= era_d;
         eentry_q <= eentry_d;
         tid_q    <= tid_d;
         tcfg_q   <= tcfg_d;
         tval_q   <= tval_d;
      end
   end

   // Combinational read port.
   always_comb begin
      bus.csr_rdata = '0;
      case (bus.csr_raddr)
         A_CRMD:   bus.csr_rdata[2:0]   = crmd_q;
         A_PRMD:   bus.csr_rdata[2:0]   = prmd_q;
         A_ECFG:   bus.csr_rdata[12:0]  = lie_q;
         A_ESTAT: begin
            bus.csr_rdata[12:0]  = is_s;
            bus.csr_rdata[21:16] = ecode_q;
         end
         A_ERA:    bus.csr_rdata        = era_q;
         A_EENTRY: bus.csr_rdata        = {eentry_q, 6'b000000};
         A_TID:    bus.csr_rdata        = tid_q;
         A_TCFG:   bus.csr_rdata[TIMER_W-1:0] = tcfg_q;
         A_TVAL:   bus.csr_rdata[TIMER_W-1:0] = tval_q;
         default:  bus.csr_rdata        = '0;
      endcase
   end

   assign bus.csr_eentry  = {eentry_q, 6'b000000};
   assign bus.csr_era     = era_q;
   assign bus.csr_plv     = crmd_q[1:0];
   assign bus.csr_int_req = crmd_q[2] & (|(is_s & lie_q));
endmodule
